// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package data_mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic GRANT_CPU = 1'b0;
   localparam logic GRANT_AUX = 1'b1;

   // Timeout counter width; covers TIMEOUT up to 255.
   localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter: on a tie the master that was not granted last wins.
module rr_arbiter_2
   import data_mem_arb_pkg::*;
(
   input  logic [1:0] req,         // bit 0 = CPU, bit 1 = AUX
   input  logic       last_grant,
   input  logic       enable,
   output logic       grant_valid,
   output logic       grant_id
);

   // Pick the winner; grant_id is only meaningful when grant_valid is high.
   always_comb begin
      grant_valid = enable & (|req);
      grant_id    = GRANT_CPU;
      if (req[0] && req[1]) begin
         grant_id = ~last_grant;
      end else if (req[1]) begin
         grant_id = GRANT_AUX;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single data-memory port between the CPU and an auxiliary master.
// One access at a time: IDLE -> ISSUE -> WAIT -> DONE, with a bounded stall timeout.
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MASK_W  = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [MASK_W-1:0] cpu_mask,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_err,
   output logic              cpu_stall,

   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_wdata,
   input  logic [MASK_W-1:0] aux_mask,
   output logic              aux_ack,
   output logic [DATA_W-1:0] aux_rdata,
   output logic              aux_err,

   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_memwrite,
   output logic              mem_memread,
   output logic [MASK_W-1:0] mem_mask,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_stall
);

   state_t            state;
   logic              last_grant;
   logic              cur_grant;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [MASK_W-1:0] lat_mask;
   logic [CNT_W-1:0]  cnt;

   logic              grant_valid;
   logic              grant_id;
   logic              finish;
   logic [DATA_W-1:0] resp_rdata;

   rr_arbiter_2 u_arb (
      .req         ({aux_req, cpu_req}),
      .last_grant  (last_grant),
      .enable      (state == ST_IDLE),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   // The access ends when memory releases its stall or the memory has stalled TIMEOUT full cycles.
   assign finish     = ~mem_stall | (cnt == CNT_W'(TIMEOUT));
   // Only a completed read returns data; writes and aborted accesses return zero.
   assign resp_rdata = (mem_stall | lat_we) ? '0 : mem_rdata;

   // CPU clock gate: hold the CPU while its request is outstanding.
   assign cpu_stall  = cpu_req & ~cpu_ack;

   // Access sequencer with request latch, timeout counter and registered responses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         last_grant   <= GRANT_AUX;
         cur_grant    <= GRANT_CPU;
         lat_we       <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         lat_mask     <= '0;
         cnt          <= '0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_mask     <= '0;
         mem_memread  <= 1'b0;
         mem_memwrite <= 1'b0;
         cpu_ack      <= 1'b0;
         cpu_rdata    <= '0;
         cpu_err      <= 1'b0;
         aux_ack      <= 1'b0;
         aux_rdata    <= '0;
         aux_err      <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         aux_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  cur_grant  <= grant_id;
                  last_grant <= grant_id;
                  if (grant_id == GRANT_CPU) begin
                     lat_we    <= cpu_we;
                     lat_addr  <= cpu_addr;
                     lat_wdata <= cpu_wdata;
                     lat_mask  <= cpu_mask;
                  end else begin
                     lat_we    <= aux_we;
                     lat_addr  <= aux_addr;
                     lat_wdata <= aux_wdata;
                     lat_mask  <= aux_mask;
                  end
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               mem_memread  <= ~lat_we;
               mem_memwrite <= lat_we;
               mem_addr     <= lat_addr;
               mem_wdata    <= lat_wdata;
               mem_mask     <= lat_mask;
               cnt          <= '0;
               state        <= ST_WAIT;
            end
            ST_WAIT: begin
               if (finish) begin
                  mem_memread  <= 1'b0;
                  mem_memwrite <= 1'b0;
                  if (cur_grant == GRANT_CPU) begin
                     cpu_ack   <= 1'b1;
                     cpu_rdata <= resp_rdata;
                     cpu_err   <= mem_stall;
                  end else begin
                     aux_ack   <= 1'b1;
                     aux_rdata <= resp_rdata;
                     aux_err   <= mem_stall;
                  end
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a small stalling memory model.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [3:0]  cpu_mask;
   logic        cpu_ack, cpu_err, cpu_stall;
   logic [31:0] cpu_rdata;
   logic        aux_req, aux_we;
   logic [31:0] aux_addr, aux_wdata;
   logic [3:0]  aux_mask;
   logic        aux_ack, aux_err;
   logic [31:0] aux_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_memwrite, mem_memread, mem_stall;
   logic [3:0]  mem_mask;

   int          checks = 0;
   int          errors = 0;

   // Memory model: stalls for the first stall_cycles cycles of each access.
   int          strobe_cnt = 0;
   int          stall_cycles = 0;
   logic [31:0] mem_rdata_v = 32'h0;
   bit          use_addr_data = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_memread || mem_memwrite) strobe_cnt <= strobe_cnt + 1;
      else                             strobe_cnt <= 0;
   end

   assign mem_stall = (mem_memread || mem_memwrite) && (strobe_cnt < stall_cycles);
   assign mem_rdata = use_addr_data ? (mem_addr + 32'h1111_0000) : mem_rdata_v;

   data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(4), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_mask(cpu_mask), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .cpu_stall(cpu_stall),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .aux_mask(aux_mask), .aux_ack(aux_ack), .aux_rdata(aux_rdata), .aux_err(aux_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_memwrite(mem_memwrite),
      .mem_memread(mem_memread), .mem_mask(mem_mask), .mem_rdata(mem_rdata),
      .mem_stall(mem_stall)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for one master's ack; cycles = -1 if it never arrives.
   task automatic wait_ack(input bit want_aux, input int max_cycles,
                           output int cycles, output int wr_cycles, output logic [31:0] seen_wdata);
      cycles     = -1;
      wr_cycles  = 0;
      seen_wdata = 32'h0;
      for (int i = 1; i <= max_cycles; i++) begin
         tick();
         if (mem_memwrite) begin
            wr_cycles++;
            seen_wdata = mem_wdata;
         end
         if ((want_aux && aux_ack) || (!want_aux && cpu_ack)) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      checks++; if (cpu_ack !== 1'b0 || aux_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got cpu=%b aux=%b expected 0 0", cpu_ack, aux_ack); end
      checks++; if (mem_memread !== 1'b0 || mem_memwrite !== 1'b0) begin errors++; $display("FAIL reset_strobes: got rd=%b wr=%b expected 0 0", mem_memread, mem_memwrite); end
      checks++; if (mem_addr !== 32'h0 || cpu_rdata !== 32'h0 || aux_rdata !== 32'h0) begin errors++; $display("FAIL reset_data: got addr=%h crd=%h ard=%h expected 0", mem_addr, cpu_rdata, aux_rdata); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %b expected 0", cpu_stall); end
      cpu_req = 1'b1;
      #1;
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_follow: got %b expected 1", cpu_stall); end
      cpu_req = 1'b0;
      reset   = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      mem_rdata_v  = 32'hDEAD_BEEF;
      stall_cycles = 0;
      cpu_we       = 1'b0;
      cpu_addr     = 32'h0000_1000;
      cpu_mask     = 4'hF;
      cpu_req      = 1'b1;
      tick();
      tick();
      checks++; if (mem_memread !== 1'b1 || mem_memwrite !== 1'b0) begin errors++; $display("FAIL read_strobes: got rd=%b wr=%b expected 1 0", mem_memread, mem_memwrite); end
      checks++; if (mem_addr !== 32'h0000_1000 || mem_mask !== 4'hF) begin errors++; $display("FAIL read_addr: got %h/%h expected 00001000/f", mem_addr, mem_mask); end
      tick();
      checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL read_ack_latency: got ack=%b expected 1 at N+3", cpu_ack); end
      checks++; if (cpu_rdata !== 32'hDEAD_BEEF || cpu_err !== 1'b0) begin errors++; $display("FAIL read_data: got %h err=%b expected deadbeef err=0", cpu_rdata, cpu_err); end
      checks++; if (mem_memread !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL read_done: got rd=%b stall=%b expected 0 0", mem_memread, cpu_stall); end
      cpu_req = 1'b0;
      tick();
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL read_ack_pulse: got %b expected 0", cpu_ack); end
   endtask

   task automatic test_back_to_back();
      int          ack_cyc [4];
      bit          ack_aux [4];
      logic [31:0] ack_dat [4];
      int          n = 0;
      logic [31:0] exp_dat;
      for (int k = 0; k < 4; k++) begin ack_cyc[k] = -1; ack_aux[k] = 1'b0; ack_dat[k] = 32'h0; end
      reset = 1'b1;
      tick();
      reset         = 1'b0;
      use_addr_data = 1'b1;
      stall_cycles  = 0;
      cpu_we = 1'b0; cpu_addr = 32'h0000_0100;
      aux_we = 1'b0; aux_addr = 32'h0000_0200; aux_mask = 4'h1;
      cpu_req = 1'b1;
      aux_req = 1'b1;
      for (int i = 1; i <= 24 && n < 4; i++) begin
         tick();
         if (cpu_ack || aux_ack) begin
            ack_cyc[n] = i;
            ack_aux[n] = aux_ack;
            ack_dat[n] = aux_ack ? aux_rdata : cpu_rdata;
            n++;
         end
      end
      cpu_req = 1'b0;
      aux_req = 1'b0;
      tick();
      use_addr_data = 1'b0;
      checks++; if (n !== 4) begin errors++; $display("FAIL b2b_count: got %0d acks expected 4", n); end
      for (int k = 0; k < 4; k++) begin
         exp_dat = (k % 2 == 1) ? 32'h1111_0200 : 32'h1111_0100;
         checks++; if (ack_aux[k] !== bit'(k % 2)) begin errors++; $display("FAIL b2b_order[%0d]: got aux=%b expected %0d", k, ack_aux[k], k % 2); end
         checks++; if (ack_cyc[k] !== 3 + 4 * k) begin errors++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", k, ack_cyc[k], 3 + 4 * k); end
         checks++; if (ack_dat[k] !== exp_dat) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, ack_dat[k], exp_dat); end
      end
   endtask

   task automatic test_write_stall();
      int          cyc, wr;
      logic [31:0] wd;
      stall_cycles = 3;
      cpu_we    = 1'b1;
      cpu_addr  = 32'h0000_0020;
      cpu_wdata = 32'h1234_5678;
      cpu_mask  = 4'h3;
      cpu_req   = 1'b1;
      wait_ack(1'b0, 30, cyc, wr, wd);
      checks++; if (cyc !== 6) begin errors++; $display("FAIL write_latency: got %0d expected 6", cyc); end
      checks++; if (wr !== 4) begin errors++; $display("FAIL write_strobe_len: got %0d expected 4", wr); end
      checks++; if (wd !== 32'h1234_5678) begin errors++; $display("FAIL write_wdata: got %h expected 12345678", wd); end
      checks++; if (cpu_rdata !== 32'h0 || cpu_err !== 1'b0) begin errors++; $display("FAIL write_resp: got %h err=%b expected 0 err=0", cpu_rdata, cpu_err); end
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int          cyc, wr;
      logic [31:0] wd;
      mem_rdata_v  = 32'hCAFE_F00D;
      stall_cycles = 1000;
      aux_we   = 1'b0;
      aux_addr = 32'h0000_0300;
      aux_req  = 1'b1;
      wait_ack(1'b1, 40, cyc, wr, wd);
      checks++; if (cyc !== 18) begin errors++; $display("FAIL timeout_latency: got %0d expected 18", cyc); end
      checks++; if (aux_err !== 1'b1 || aux_rdata !== 32'h0) begin errors++; $display("FAIL timeout_resp: got err=%b rdata=%h expected 1 0", aux_err, aux_rdata); end
      checks++; if (mem_memread !== 1'b0) begin errors++; $display("FAIL timeout_strobe: got %b expected 0", mem_memread); end
      aux_req = 1'b0;
      tick();
      stall_cycles = 0;
      aux_addr = 32'h0000_0304;
      aux_req  = 1'b1;
      wait_ack(1'b1, 10, cyc, wr, wd);
      checks++; if (cyc !== 3) begin errors++; $display("FAIL after_timeout_latency: got %0d expected 3", cyc); end
      checks++; if (aux_err !== 1'b0 || aux_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL after_timeout_resp: got err=%b rdata=%h expected 0 cafef00d", aux_err, aux_rdata); end
      aux_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      int          cyc, wr;
      logic [31:0] wd;
      stall_cycles = 1000;
      mem_rdata_v  = 32'h5555_AAAA;
      cpu_we   = 1'b0;
      cpu_addr = 32'h0000_0400;
      cpu_req  = 1'b1;
      tick(); tick(); tick();
      checks++; if (mem_memread !== 1'b1) begin errors++; $display("FAIL resetmid_pre: got rd=%b expected 1", mem_memread); end
      reset = 1'b1;
      tick();
      checks++; if (mem_memread !== 1'b0 || mem_memwrite !== 1'b0 || cpu_ack !== 1'b0 || aux_ack !== 1'b0) begin errors++; $display("FAIL resetmid_outputs: got rd=%b wr=%b cack=%b aack=%b expected 0", mem_memread, mem_memwrite, cpu_ack, aux_ack); end
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL resetmid_stall: got %b expected 1", cpu_stall); end
      reset        = 1'b0;
      stall_cycles = 0;
      aux_addr     = 32'h0000_0500;
      aux_req      = 1'b1;
      wait_ack(1'b0, 10, cyc, wr, wd);
      checks++; if (cyc !== 3 || aux_ack !== 1'b0) begin errors++; $display("FAIL resetmid_tie_cpu: got cycles=%0d aux_ack=%b expected 3 0", cyc, aux_ack); end
      checks++; if (cpu_rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL resetmid_data: got %h expected 5555aaaa", cpu_rdata); end
      cpu_req = 1'b0;
      wait_ack(1'b1, 10, cyc, wr, wd);
      checks++; if (cyc !== 4) begin errors++; $display("FAIL resetmid_aux_next: got %0d expected 4", cyc); end
      aux_req = 1'b0;
      tick();
   endtask

   task automatic test_addr_change();
      int          cyc, wr;
      logic [31:0] wd;
      stall_cycles = 3;
      mem_rdata_v  = 32'h0BAD_F00D;
      cpu_we   = 1'b0;
      cpu_addr = 32'h0000_0040;
      cpu_req  = 1'b1;
      #1;
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL chg_stall_req: got %b expected 1", cpu_stall); end
      tick(); tick();
      cpu_addr  = 32'h0000_0080;
      cpu_wdata = 32'hFFFF_FFFF;
      cpu_we    = 1'b1;
      tick();
      checks++; if (mem_addr !== 32'h0000_0040 || mem_memread !== 1'b1) begin errors++; $display("FAIL chg_addr_held: got %h rd=%b expected 00000040 1", mem_addr, mem_memread); end
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL chg_stall_wait: got %b expected 1", cpu_stall); end
      wait_ack(1'b0, 10, cyc, wr, wd);
      checks++; if (cyc !== 3) begin errors++; $display("FAIL chg_latency: got %0d expected 3", cyc); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL chg_stall_ack: got %b expected 0", cpu_stall); end
      checks++; if (cpu_rdata !== 32'h0BAD_F00D || wr !== 0) begin errors++; $display("FAIL chg_read: got %h wr=%0d expected 0badf00d 0", cpu_rdata, wr); end
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_mask = 4'h0;
      aux_req = 1'b0; aux_we = 1'b0; aux_addr = 32'h0; aux_wdata = 32'h0; aux_mask = 4'h0;
      tick();
      test_reset();
      test_single_read();
      test_back_to_back();
      test_write_stall();
      test_timeout();
      test_reset_mid();
      test_addr_change();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
